// File: rtl/mtr_duty_ctrl.sv
// -----------------------------------------------------------------------------
// mtr_duty_ctrl
//
// Purpose:
//   Upstream stage of the motor PWM generator. Turns a signed 12-bit drive
//   command into an 11-bit unsigned duty, a direction flag and a brake flag
//   for the PWM / H-bridge path. All state advances only on the PWM period
//   pulse (i_pwm_synch), so the duty never changes in the middle of a period.
//   Every direction reversal ramps duty to zero, then spends DEADTIME periods
//   braking at zero duty before the direction flips.
//
// Optional feature (macro MTR_DUTY_SLEW_EN):
//   defined   : duty moves at most SLEW_STEP LSBs per PWM period.
//   undefined : duty jumps straight to its target on each period; the
//               ramp-down of a reversal becomes a single step to zero.
//
// Ports:
//   i_clk        in   1   system clock, rising edge
//   i_rst        in   1   synchronous active-high reset (wins over a tick)
//   i_drive      in  12   signed drive command, sampled only on a tick
//   i_pwm_synch  in   1   one-clock pulse per PWM period ("tick")
//   o_duty       out 11   unsigned duty to the PWM block (registered)
//   o_fwd        out  1   1 = forward, 0 = reverse (registered)
//   o_brake      out  1   high only during dead time (registered)
//   o_reversing  out  1   high while ramping down or in dead time (registered)
//
// Parameters:
//   SLEW_STEP  max duty change per period, 1..2047
//   DEADTIME   periods at zero duty with brake before the flip, >= 1
//   DUTY_MAX   duty magnitude ceiling, 1..2047
// -----------------------------------------------------------------------------
module mtr_duty_ctrl #(
  parameter int SLEW_STEP = 16,
  parameter int DEADTIME  = 2,
  parameter int DUTY_MAX  = 2040
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [11:0] i_drive,
  input  logic        i_pwm_synch,
  output logic [10:0] o_duty,
  output logic        o_fwd,
  output logic        o_brake,
  output logic        o_reversing
);

  // Dead-time counter is wide enough to hold DEADTIME itself.
  localparam int CNT_W = (DEADTIME < 2) ? 1 : $clog2(DEADTIME + 1);
  localparam logic [CNT_W-1:0] DEAD_INIT = CNT_W'(DEADTIME);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [11:0]      MAX12     = 12'(DUTY_MAX);
`ifdef MTR_DUTY_SLEW_EN
  localparam logic [11:0]      STEP12    = 12'(SLEW_STEP);
`endif

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_REVERSE = 2'd1,
    ST_DEAD    = 2'd2
  } state_t;

  state_t           r_state;
  logic [10:0]      r_duty;
  logic             r_fwd;
  logic             r_brake;
  logic             r_reversing;
  logic [CNT_W-1:0] r_cnt;

  state_t           w_state_nx;
  logic [10:0]      w_duty_nx;
  logic             w_fwd_nx;
  logic             w_brake_nx;
  logic             w_rev_nx;
  logic [CNT_W-1:0] w_cnt_nx;

  logic             w_neg;
  logic             w_zero;
  logic             w_tgt_fwd;
  logic             w_mismatch;
  logic [11:0]      w_abs;
  logic [10:0]      w_tgt_mag;

  // One period's move from cur toward tgt. With slew limiting the step is
  // clamped to SLEW_STEP; the comparison is done on the difference, so the
  // result always lies between cur and tgt and can neither wrap below zero
  // nor overshoot the (already saturated) target.
  function automatic logic [10:0] f_slew(input logic [10:0] cur,
                                         input logic [10:0] tgt);
    logic [10:0] res;
`ifdef MTR_DUTY_SLEW_EN
    logic [11:0] diff;
    if (tgt >= cur) begin
      diff = {1'b0, tgt} - {1'b0, cur};
      if (diff <= STEP12) begin
        res = tgt;
      end else begin
        res = cur + STEP12[10:0];
      end
    end else begin
      diff = {1'b0, cur} - {1'b0, tgt};
      if (diff <= STEP12) begin
        res = tgt;
      end else begin
        res = cur - STEP12[10:0];
      end
    end
`else
    res = tgt | (cur & 11'd0);
`endif
    return res;
  endfunction

  // Target magnitude and direction from the drive command. The magnitude is
  // formed at 12 bits so that -2048 yields 2048 before saturation.
  always_comb begin
    w_neg      = i_drive[11];
    w_zero     = (i_drive == 12'd0);
    w_tgt_fwd  = ~w_neg;
    w_abs      = w_neg ? (12'd0 - i_drive) : i_drive;
    w_tgt_mag  = (w_abs > MAX12) ? MAX12[10:0] : w_abs[10:0];
    // A zero command never counts as a reversal request.
    w_mismatch = ~w_zero & (w_tgt_fwd != r_fwd);
  end

  // Next-state and next-output logic; everything holds unless a tick arrives.
  always_comb begin
    w_state_nx = r_state;
    w_duty_nx  = r_duty;
    w_fwd_nx   = r_fwd;
    w_brake_nx = r_brake;
    w_cnt_nx   = r_cnt;
    if (i_pwm_synch) begin
      case (r_state)
        ST_RUN: begin
          w_brake_nx = 1'b0;
          if (w_mismatch) begin
            if (r_duty != 11'd0) begin
              w_duty_nx  = f_slew(r_duty, 11'd0);
              w_state_nx = ST_REVERSE;
            end else begin
              w_state_nx = ST_DEAD;
              w_brake_nx = 1'b1;
              w_cnt_nx   = DEAD_INIT;
            end
          end else begin
            w_duty_nx = f_slew(r_duty, w_tgt_mag);
          end
        end
        ST_REVERSE: begin
          w_brake_nx = 1'b0;
          if (w_zero || (w_tgt_fwd == r_fwd)) begin
            // Reversal abandoned: resume normal tracking on this same tick.
            w_state_nx = ST_RUN;
            w_duty_nx  = f_slew(r_duty, w_tgt_mag);
          end else if (r_duty == 11'd0) begin
            w_state_nx = ST_DEAD;
            w_brake_nx = 1'b1;
            w_cnt_nx   = DEAD_INIT;
          end else begin
            w_duty_nx = f_slew(r_duty, 11'd0);
          end
        end
        ST_DEAD: begin
          // Dead time cannot be aborted; duty stays zero even on the exit tick.
          w_duty_nx = 11'd0;
          if (r_cnt == CNT_ONE) begin
            w_fwd_nx   = ~r_fwd;
            w_brake_nx = 1'b0;
            w_cnt_nx   = CNT_ZERO;
            w_state_nx = ST_RUN;
          end else begin
            w_brake_nx = 1'b1;
            w_cnt_nx   = r_cnt - CNT_ONE;
          end
        end
        default: begin
          // Unreachable encoding: fall back to a safe, stopped RUN.
          w_state_nx = ST_RUN;
          w_duty_nx  = 11'd0;
          w_brake_nx = 1'b0;
          w_cnt_nx   = CNT_ZERO;
        end
      endcase
    end else begin
      w_state_nx = r_state;
      w_duty_nx  = r_duty;
      w_fwd_nx   = r_fwd;
      w_brake_nx = r_brake;
      w_cnt_nx   = r_cnt;
    end
    w_rev_nx = (w_state_nx != ST_RUN);
  end

  // State and output registers; reset has priority over a simultaneous tick.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_RUN;
      r_duty      <= 11'd0;
      r_fwd       <= 1'b1;
      r_brake     <= 1'b0;
      r_reversing <= 1'b0;
      r_cnt       <= CNT_ZERO;
    end else begin
      r_state     <= w_state_nx;
      r_duty      <= w_duty_nx;
      r_fwd       <= w_fwd_nx;
      r_brake     <= w_brake_nx;
      r_reversing <= w_rev_nx;
      r_cnt       <= w_cnt_nx;
    end
  end

  assign o_duty      = r_duty;
  assign o_fwd       = r_fwd;
  assign o_brake     = r_brake;
  assign o_reversing = r_reversing;

endmodule
